// File: rtl/dcp_hex_tx_pkg.sv
// -----------------------------------------------------------------------------
// dcp_hex_tx_pkg
// Shared definitions for the debug command print path: print FSM state
// encodings, separator codes and the ASCII characters the hex printer emits.
// No ports (package).
// -----------------------------------------------------------------------------
package dcp_hex_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DIGIT = 2'd1,
        ST_SEP1  = 2'd2,
        ST_SEP2  = 2'd3
    } state_e;

    // Separator codes carried alongside each word
    localparam logic [1:0] SEP_NONE  = 2'b00;
    localparam logic [1:0] SEP_SPACE = 2'b01;
    localparam logic [1:0] SEP_CRLF  = 2'b10;
    localparam logic [1:0] SEP_COLON = 2'b11;

    localparam logic [7:0] ASCII_SPACE   = 8'h20;
    localparam logic [7:0] ASCII_CR      = 8'h0D;
    localparam logic [7:0] ASCII_LF      = 8'h0A;
    localparam logic [7:0] ASCII_COLON   = 8'h3A;
    localparam logic [7:0] ASCII_ZERO    = 8'h30;
    localparam logic [7:0] ASCII_UPPER_A = 8'h41;
    localparam logic [7:0] ASCII_LOWER_A = 8'h61;

    // First separator character; CR LF is the only two-character separator.
    function automatic logic [7:0] sep_first_char(input logic [1:0] sep);
        case (sep)
            SEP_SPACE: return ASCII_SPACE;
            SEP_CRLF:  return ASCII_CR;
            SEP_COLON: return ASCII_COLON;
            default:   return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/dcp_hex_tx_hex_nibble_ascii.sv
// -----------------------------------------------------------------------------
// hex_nibble_ascii
// Combinational conversion of one hex nibble to its ASCII character.
// Parameters:
//   UPPER     1 -> 'A'..'F' for 10..15, 0 -> 'a'..'f'
// Ports:
//   nibble_i  in   4  value 0..15
//   ascii_o   out  8  ASCII character '0'..'9', 'A'/'a'..'F'/'f'
// -----------------------------------------------------------------------------
module hex_nibble_ascii
    import dcp_hex_tx_pkg::*;
#(
    parameter bit UPPER = 1'b1
) (
    input  logic [3:0] nibble_i,
    output logic [7:0] ascii_o
);

    localparam logic [7:0] ALPHA_BASE = UPPER ? ASCII_UPPER_A : ASCII_LOWER_A;

    always_comb begin
        if (nibble_i < 4'd10) begin
            ascii_o = ASCII_ZERO + {4'h0, nibble_i};
        end else begin
            ascii_o = ALPHA_BASE + {4'h0, nibble_i} - 8'd10;
        end
    end

endmodule

// File: rtl/dcp_hex_tx.sv
// -----------------------------------------------------------------------------
// dcp_hex_tx
// Print stage for the debug command units: takes one 32-bit word plus a
// separator code and streams it toward the UART as ASCII hex (most
// significant digit first) followed by the optional separator.
// Parameters:
//   DIGITS   hex digits per word, taken from the low nibbles (legal 1..8)
//   UPPER    1 -> upper-case hex letters, 0 -> lower-case
// Ports:
//   clk       in   1   clock, rising edge
//   rst       in   1   asynchronous reset, active low
//   vld_tx    in   1   upstream word valid
//   d_tx      in   32  word to print
//   sep_tx    in   2   separator: 00 none, 01 space, 10 CR LF, 11 ':'
//   rdy_tx    out  1   stage idle and able to accept a word
//   out_vld   out  1   out_byte valid toward the UART
//   out_byte  out  8   ASCII character
//   out_rdy   in   1   UART takes out_byte
//   busy      out  1   word in progress
// -----------------------------------------------------------------------------
module dcp_hex_tx
    import dcp_hex_tx_pkg::*;
#(
    parameter int unsigned DIGITS = 8,
    parameter bit          UPPER  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vld_tx,
    input  logic [31:0] d_tx,
    input  logic [1:0]  sep_tx,
    output logic        rdy_tx,
    output logic        out_vld,
    output logic [7:0]  out_byte,
    input  logic        out_rdy,
    output logic        busy
);

    localparam logic [2:0] CNT_INIT = 3'(DIGITS - 1);
    // Bit position of the most significant printed nibble
    localparam int         MSN_LSB  = 4 * (int'(DIGITS) - 1);

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] word_q, word_d;
    logic [1:0]  sep_q, sep_d;
    logic        out_vld_q, out_vld_d;
    logic [7:0]  out_byte_q, out_byte_d;

    logic        hs;
    logic [2:0]  cnt_m1;
    logic [3:0]  nibble;
    logic [7:0]  digit_ascii;

    assign hs     = out_vld_q & out_rdy;
    assign cnt_m1 = cnt_q - 3'd1;

    // Outputs are registered, so the byte loaded on a given edge is the one
    // for the next position: the top digit of the incoming word on accept,
    // otherwise the digit one below the one currently being presented.
    assign nibble = (state_q == ST_IDLE) ? d_tx[MSN_LSB +: 4]
                                         : word_q[{cnt_m1, 2'b00} +: 4];

    hex_nibble_ascii #(
        .UPPER (UPPER)
    ) u_nibble (
        .nibble_i (nibble),
        .ascii_o  (digit_ascii)
    );

    // ---------------------------------------------------------------- state
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 3'd0;
            word_q     <= 32'd0;
            sep_q      <= SEP_NONE;
            out_vld_q  <= 1'b0;
            out_byte_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            word_q     <= word_d;
            sep_q      <= sep_d;
            out_vld_q  <= out_vld_d;
            out_byte_q <= out_byte_d;
        end
    end

    // ----------------------------------------------------------- next state
    // NOTE: every variable gets a hold default before the case so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        sep_d   = sep_q;
        case (state_q)
            ST_IDLE: begin
                if (vld_tx) begin
                    state_d = ST_DIGIT;
                    cnt_d   = CNT_INIT;
                    word_d  = d_tx;
                    sep_d   = sep_tx;
                end
            end
            ST_DIGIT: begin
                if (hs) begin
                    if (cnt_q != 3'd0) begin
                        cnt_d = cnt_m1;
                    end else begin
                        state_d = (sep_q == SEP_NONE) ? ST_IDLE : ST_SEP1;
                    end
                end
            end
            ST_SEP1: begin
                if (hs) begin
                    state_d = (sep_q == SEP_CRLF) ? ST_SEP2 : ST_IDLE;
                end
            end
            ST_SEP2: begin
                if (hs) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------- outputs
    // Next presented byte; out_vld drops together with the return to IDLE.
    always_comb begin
        out_vld_d  = out_vld_q;
        out_byte_d = out_byte_q;
        case (state_q)
            ST_IDLE: begin
                if (vld_tx) begin
                    out_vld_d  = 1'b1;
                    out_byte_d = digit_ascii;
                end
            end
            ST_DIGIT: begin
                if (hs) begin
                    if (cnt_q != 3'd0) begin
                        out_byte_d = digit_ascii;
                    end else if (sep_q == SEP_NONE) begin
                        out_vld_d = 1'b0;
                    end else begin
                        out_byte_d = sep_first_char(sep_q);
                    end
                end
            end
            ST_SEP1: begin
                if (hs) begin
                    if (sep_q == SEP_CRLF) begin
                        out_byte_d = ASCII_LF;
                    end else begin
                        out_vld_d = 1'b0;
                    end
                end
            end
            ST_SEP2: begin
                if (hs) begin
                    out_vld_d = 1'b0;
                end
            end
            default: out_vld_d = 1'b0;
        endcase
    end

    assign rdy_tx   = (state_q == ST_IDLE);
    assign busy     = (state_q != ST_IDLE);
    assign out_vld  = out_vld_q;
    assign out_byte = out_byte_q;

endmodule

// File: tb/tb_dcp_hex_tx.sv
// -----------------------------------------------------------------------------
// tb_dcp_hex_tx
// Self-checking bench for dcp_hex_tx. Two instances: the default 8-digit
// upper-case printer (A) and a 2-digit lower-case printer (B). Inputs change
// on the falling edge, outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_dcp_hex_tx;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    // Instance A: DIGITS=8, UPPER=1
    logic        vld_a = 1'b0;
    logic [31:0] d_a = 32'd0;
    logic [1:0]  sep_a = 2'b00;
    logic        ordy_a = 1'b0;
    logic        rdy_a, ovld_a, busy_a;
    logic [7:0]  obyte_a;

    // Instance B: DIGITS=2, UPPER=0
    logic        vld_b = 1'b0;
    logic [31:0] d_b = 32'd0;
    logic [1:0]  sep_b = 2'b00;
    logic        ordy_b = 1'b0;
    logic        rdy_b, ovld_b, busy_b;
    logic [7:0]  obyte_b;

    dcp_hex_tx u_dut_a (
        .clk      (clk),
        .rst      (rst),
        .vld_tx   (vld_a),
        .d_tx     (d_a),
        .sep_tx   (sep_a),
        .rdy_tx   (rdy_a),
        .out_vld  (ovld_a),
        .out_byte (obyte_a),
        .out_rdy  (ordy_a),
        .busy     (busy_a)
    );

    dcp_hex_tx #(
        .DIGITS (2),
        .UPPER  (1'b0)
    ) u_dut_b (
        .clk      (clk),
        .rst      (rst),
        .vld_tx   (vld_b),
        .d_tx     (d_b),
        .sep_tx   (sep_b),
        .rdy_tx   (rdy_b),
        .out_vld  (ovld_b),
        .out_byte (obyte_b),
        .out_rdy  (ordy_b),
        .busy     (busy_b)
    );

    // Selected instance view
    bit         use_b = 1'b0;
    logic       c_ovld, c_rdy;
    logic [7:0] c_obyte;
    assign c_ovld  = use_b ? ovld_b  : ovld_a;
    assign c_rdy   = use_b ? rdy_b   : rdy_a;
    assign c_obyte = use_b ? obyte_b : obyte_a;

    int pass_cnt  = 0;
    int check_cnt = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         first_vld_cyc;
    int         idle_cyc;
    bit         stable_ok;
    bit         timed_out;

    // ------------------------------------------------------ reference model
    // Printed text of one word: DIGITS hex characters, then the separator.
    function automatic void build_expect(input logic [31:0] w, input logic [1:0] s,
                                         input int digits, input bit upper);
        exp_q.delete();
        for (int i = digits - 1; i >= 0; i--) begin
            int n;
            n = int'((w >> (4 * i)) & 32'hF);
            if (n < 10) exp_q.push_back(8'(48 + n));
            else        exp_q.push_back(8'((upper ? 65 : 97) + n - 10));
        end
        case (s)
            2'b01: exp_q.push_back(8'h20);
            2'b10: begin exp_q.push_back(8'h0D); exp_q.push_back(8'h0A); end
            2'b11: exp_q.push_back(8'h3A);
            default: ;
        endcase
    endfunction

    function automatic bit queues_equal();
        if (got_q.size() != exp_q.size()) return 1'b0;
        foreach (got_q[i]) if (got_q[i] !== exp_q[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic string q2s(input logic [7:0] q[$]);
        string s = "";
        foreach (q[i]) s = {s, $sformatf("%02h ", q[i])};
        return s;
    endfunction

    // ------------------------------------------------------------- drivers
    task automatic drive(input logic v, input logic [31:0] d, input logic [1:0] s);
        if (use_b) begin vld_b = v; d_b = d; sep_b = s; end
        else       begin vld_a = v; d_a = d; sep_a = s; end
    endtask

    task automatic drive_rdy(input logic r);
        if (use_b) ordy_b = r;
        else       ordy_a = r;
    endtask

    // Sends one word and records the bytes the UART side takes. mode 0:
    // out_rdy always high, 1: high on odd cycles, 2: random. Cycle 1 is the
    // falling edge right after the accepting rising edge.
    task automatic xfer(input logic [31:0] w, input logic [1:0] s, input int mode);
        logic       r;
        logic       prev_vld, prev_rdy;
        logic [7:0] prev_byte;
        got_q.delete();
        first_vld_cyc = -1;
        idle_cyc      = -1;
        stable_ok     = 1'b1;
        timed_out     = 1'b0;
        @(negedge clk);
        drive(1'b1, w, s);
        drive_rdy(1'b1);
        @(negedge clk);
        // Captured data must not follow later input changes
        drive(1'b0, $urandom(), ~s);
        prev_vld  = 1'b0;
        prev_rdy  = 1'b0;
        prev_byte = 8'h00;
        for (int c = 1; c <= 200; c++) begin
            if (c > 1) @(negedge clk);
            if (prev_vld && !prev_rdy && (c_ovld !== 1'b1 || c_obyte !== prev_byte))
                stable_ok = 1'b0;
            if (c_ovld === 1'b1 && first_vld_cyc < 0) first_vld_cyc = c;
            if (c_rdy === 1'b1) begin
                idle_cyc = c;
                break;
            end
            case (mode)
                0:       r = 1'b1;
                1:       r = (c % 2) == 1;
                default: r = 1'($urandom_range(0, 1));
            endcase
            drive_rdy(r);
            if (c_ovld === 1'b1 && r) got_q.push_back(c_obyte);
            prev_vld  = c_ovld;
            prev_rdy  = r;
            prev_byte = c_obyte;
        end
        if (idle_cyc < 0) timed_out = 1'b1;
    endtask

    // --------------------------------------------------------------- tests
    task automatic test_reset();
        #12;
        check_cnt++;
        if (rdy_a !== 1'b1 || ovld_a !== 1'b0 || busy_a !== 1'b0)
            $display("FAIL reset_ctrl_a: rdy=%b vld=%b busy=%b, required 1 0 0", rdy_a, ovld_a, busy_a);
        else pass_cnt++;
        check_cnt++;
        if (obyte_a !== 8'h00)
            $display("FAIL reset_byte_a: got %02h, required 00", obyte_a);
        else pass_cnt++;
        check_cnt++;
        if (rdy_b !== 1'b1 || ovld_b !== 1'b0 || busy_b !== 1'b0 || obyte_b !== 8'h00)
            $display("FAIL reset_b: rdy=%b vld=%b busy=%b byte=%02h, required 1 0 0 00",
                     rdy_b, ovld_b, busy_b, obyte_b);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_cnt++;
        if (rdy_a !== 1'b1 || ovld_a !== 1'b0)
            $display("FAIL post_reset_idle: rdy=%b vld=%b, required 1 0", rdy_a, ovld_a);
        else pass_cnt++;
    endtask

    task automatic test_spaced_word();
        use_b = 1'b0;
        xfer(32'h12AB_CD09, 2'b01, 0);
        build_expect(32'h12AB_CD09, 2'b01, 8, 1'b1);
        check_cnt++;
        if (!queues_equal())
            $display("FAIL spaced_bytes: got %s required %s", q2s(got_q), q2s(exp_q));
        else pass_cnt++;
        check_cnt++;
        if (first_vld_cyc != 1)
            $display("FAIL spaced_latency: got %0d required 1", first_vld_cyc);
        else pass_cnt++;
        check_cnt++;
        if (idle_cyc != 10 || timed_out)
            $display("FAIL spaced_idle_cycle: got %0d required 10", idle_cyc);
        else pass_cnt++;
    endtask

    task automatic test_crlf_stall();
        use_b = 1'b0;
        xfer(32'hDEAD_BEEF, 2'b10, 1);
        build_expect(32'hDEAD_BEEF, 2'b10, 8, 1'b1);
        check_cnt++;
        if (!queues_equal())
            $display("FAIL crlf_bytes: got %s required %s", q2s(got_q), q2s(exp_q));
        else pass_cnt++;
        check_cnt++;
        if (stable_ok !== 1'b1)
            $display("FAIL crlf_hold_stable: got %b required 1", stable_ok);
        else pass_cnt++;
        check_cnt++;
        if (idle_cyc != 20 || timed_out)
            $display("FAIL crlf_idle_cycle: got %0d required 20", idle_cyc);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] e1[$];
        logic [7:0] e2[$];
        logic       ev;
        logic [7:0] eb;
        int         n1;
        int         n2;
        use_b = 1'b0;
        build_expect(32'h0000_0000, 2'b00, 8, 1'b1);
        e1 = exp_q;
        build_expect(32'hFFFF_FFFF, 2'b11, 8, 1'b1);
        e2 = exp_q;
        n1 = e1.size();
        n2 = e2.size();
        @(negedge clk);
        drive(1'b1, 32'h0000_0000, 2'b00);
        drive_rdy(1'b1);
        for (int c = 1; c <= n1 + n2 + 3; c++) begin
            @(negedge clk);
            // Word 1 occupies cycles 1..n1, one dead cycle, then word 2
            if (c <= n1) begin
                ev = 1'b1; eb = e1[c - 1];
            end else if (c > n1 + 1 && c <= n1 + 1 + n2) begin
                ev = 1'b1; eb = e2[c - n1 - 2];
            end else begin
                ev = 1'b0; eb = 8'h00;
            end
            check_cnt++;
            if (c_ovld !== ev || c_rdy !== !ev || (ev && c_obyte !== eb))
                $display("FAIL b2b_cycle%0d: vld=%b rdy=%b byte=%02h required vld=%b rdy=%b byte=%02h",
                         c, c_ovld, c_rdy, c_obyte, ev, !ev, eb);
            else pass_cnt++;
            if (c == 1)      drive(1'b1, 32'hFFFF_FFFF, 2'b11);
            if (c == n1 + 2) drive(1'b0, 32'h0, 2'b00);
        end
    endtask

    task automatic test_narrow_lower();
        use_b = 1'b1;
        xfer(32'h1234_56AF, 2'b01, 0);
        build_expect(32'h1234_56AF, 2'b01, 2, 1'b0);
        check_cnt++;
        if (!queues_equal())
            $display("FAIL narrow_bytes: got %s required %s", q2s(got_q), q2s(exp_q));
        else pass_cnt++;
        check_cnt++;
        if (first_vld_cyc != 1 || idle_cyc != 4 || timed_out)
            $display("FAIL narrow_timing: first=%0d idle=%0d required 1 4", first_vld_cyc, idle_cyc);
        else pass_cnt++;
        use_b = 1'b0;
    endtask

    task automatic test_reset_mid_word();
        logic [31:0] w;
        bit          quiet;
        use_b = 1'b0;
        @(negedge clk);
        drive(1'b1, 32'h89AB_CDEF, 2'b01);
        drive_rdy(1'b1);
        @(negedge clk);
        drive(1'b0, 32'h0, 2'b00);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        // Three digits taken; now reset away from any clock edge
        #2 rst = 1'b0;
        #1;
        check_cnt++;
        if (ovld_a !== 1'b0 || rdy_a !== 1'b1 || busy_a !== 1'b0 || obyte_a !== 8'h00)
            $display("FAIL midword_async_reset: vld=%b rdy=%b busy=%b byte=%02h required 0 1 0 00",
                     ovld_a, rdy_a, busy_a, obyte_a);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b1;
        quiet = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (ovld_a !== 1'b0) quiet = 1'b0;
        end
        check_cnt++;
        if (quiet !== 1'b1)
            $display("FAIL midword_dropped: got out_vld activity, required none");
        else pass_cnt++;
        w = $urandom();
        xfer(w, 2'b11, 0);
        build_expect(w, 2'b11, 8, 1'b1);
        check_cnt++;
        if (!queues_equal() || first_vld_cyc != 1)
            $display("FAIL midword_next_word: got %s (first %0d) required %s (first 1)",
                     q2s(got_q), first_vld_cyc, q2s(exp_q));
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic [31:0] w;
        logic [1:0]  s;
        for (int i = 0; i < 24; i++) begin
            use_b = (i % 4) == 3;
            w = $urandom();
            s = 2'($urandom_range(0, 3));
            xfer(w, s, 2);
            build_expect(w, s, use_b ? 2 : 8, !use_b);
            check_cnt++;
            if (!queues_equal() || timed_out)
                $display("FAIL random%0d_bytes: got %s required %s", i, q2s(got_q), q2s(exp_q));
            else pass_cnt++;
            check_cnt++;
            if (stable_ok !== 1'b1 || first_vld_cyc != 1)
                $display("FAIL random%0d_timing: stable=%b first=%0d required 1 1",
                         i, stable_ok, first_vld_cyc);
            else pass_cnt++;
        end
        use_b = 1'b0;
    endtask

    initial begin
        test_reset();
        test_spaced_word();
        test_crlf_stall();
        test_back_to_back();
        test_narrow_lower();
        test_reset_mid_word();
        test_random();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
